// File: rtl/inst_sram_like_bridge.sv
// ----------------------------------------------------------------------------
// inst_sram_like_bridge
//
// Instruction-fetch front end. It turns the core's F-stage fetch port into
// single-word reads on an sram-like bus (req / addr_ok / data_ok). One read is
// issued per fetch, and instrStall stays high until the word returns. If the
// whole pipeline is frozen (longest_stall) when the word arrives, the word is
// held in a buffer, so that no fetch is lost or duplicated.
//
// Parameters:
//   ADDR_W  fetch address width
//   DATA_W  instruction width
//   PERF_W  perf counter width (only with IBRIDGE_PERF_CNT_EN)
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   pcF, instr_enF  fetch address / fetch request from the core
//   instrF          fetched instruction (0 = NOP when nothing is delivered)
//   instrStall      fetch not complete, core must hold F
//   longest_stall   whole-pipeline stall from the core
//   inst_req .. inst_wdata               sram-like request side
//   inst_addr_ok, inst_data_ok, inst_rdata  sram-like response side
//   perf_req_cnt, perf_stall_cnt         saturating counters (optional)
//
// Build option: define IBRIDGE_PERF_CNT_EN to add the perf counters.
// ----------------------------------------------------------------------------
module inst_sram_like_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef IBRIDGE_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    // core F-stage side
    input  logic [ADDR_W-1:0] pcF,
    input  logic              instr_enF,
    output logic [DATA_W-1:0] instrF,
    output logic              instrStall,
    input  logic              longest_stall,
    // sram-like bus side
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata
`ifdef IBRIDGE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_req_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_q;

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_enF) begin
                        addr_q  <= pcF;
                        state_q <= inst_addr_ok ? StWait : StReq;
                    end
                end
                StReq: begin
                    if (inst_addr_ok) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // data_ok is only meaningful here. Elsewhere it is a stray
                    // pulse (e.g. left over from before a reset).
                    if (inst_data_ok) begin
                        buf_q   <= inst_rdata;
                        state_q <= longest_stall ? StDone : StIdle;
                    end
                end
                StDone: begin
                    // The core consumes buf_q in the cycle the freeze lifts.
                    if (!longest_stall) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. instrStall is built without longest_stall, because the core
    // folds instrStall into longest_stall and a dependency would form a loop.
    // ------------------------------------------------------------------------
    always_comb begin
        inst_req   = 1'b0;
        inst_addr  = addr_q;
        instrStall = 1'b0;
        instrF     = '0;
        unique case (state_q)
            StIdle: begin
                inst_req   = instr_enF;
                inst_addr  = pcF;
                instrStall = instr_enF;
            end
            StReq: begin
                inst_req   = 1'b1;
                instrStall = 1'b1;
            end
            StWait: begin
                instrStall = ~inst_data_ok;
                if (inst_data_ok) begin
                    instrF = inst_rdata;
                end
            end
            StDone: begin
                instrF = buf_q;
            end
            default: ;
        endcase
    end

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = '0;

`ifdef IBRIDGE_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    logic [PERF_W-1:0] perf_req_q;
    logic [PERF_W-1:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (inst_req && inst_addr_ok && (perf_req_q != '1)) begin
                perf_req_q <= perf_req_q + PERF_W'(1);
            end
            if (instrStall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_sram_like_bridge.sv
// ----------------------------------------------------------------------------
// tb_inst_sram_like_bridge
//
// Directed scenarios for latency, address hold, pipeline freeze, stray
// data_ok and mid-transaction reset, followed by a randomized phase. In the
// randomized phase a core model issues fetches and a bus model answers with
// random delays. The expected instruction for each fetch is mem(pc), which is
// pushed into a queue at issue time. A separate monitor pops and compares each
// time the core consumes an instruction or the bus accepts an address.
// ----------------------------------------------------------------------------
module tb_inst_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        instr_enF;
    logic [31:0] instrF;
    logic        instrStall;
    logic        longest_stall;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
`ifdef IBRIDGE_PERF_CNT_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    inst_sram_like_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .instr_enF    (instr_enF),
        .instrF       (instrF),
        .instrStall   (instrStall),
        .longest_stall(longest_stall),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
`ifdef IBRIDGE_PERF_CNT_EN
        ,
        .perf_req_cnt  (perf_req_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          rnd = 1'b0;
    logic [31:0] pc_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic req, input logic stall,
                           input logic [31:0] ins);
        @(negedge clk);
        chk({name, "_req"}, inst_req, req);
        chk({name, "_stall"}, instrStall, stall);
        chk({name, "_instr"}, instrF, ins);
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard for the randomized phase
    // ------------------------------------------------------------------------
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          bus_busy = 1'b0;

    always @(negedge clk) begin
        if (rnd) begin
            // An unaccepted request must stay up with an unchanged address.
            if (prev_hold) begin
                chk("req_held", inst_req, 1'b1);
                chk("addr_held", inst_addr, prev_addr);
            end
            if (inst_req) begin
                chk("wr_const", inst_wr, 1'b0);
                chk("size_const", inst_size, 2'b10);
                chk("wdata_const", inst_wdata, 32'h0);
            end
            if (inst_req && inst_addr_ok) begin
                if (bus_busy) fail("one_outstanding", "got second handshake, required none");
                if (pc_q.size() == 0) fail("extra_req", "got handshake, required none");
                else chk("req_addr", inst_addr, pc_q.pop_front());
            end
            if (inst_data_ok) bus_busy = 1'b0;
            if (inst_req && inst_addr_ok) bus_busy = 1'b1;
            // Delivery to the core
            if (instr_enF && !instrStall && !longest_stall) begin
                if (exp_q.size() == 0) fail("extra_instr", "got delivery, required none");
                else chk("instr", instrF, exp_q.pop_front());
            end
            if (instrStall || !instr_enF) chk("nop_instr", instrF, 32'h0);
            if (!instr_enF) chk("idle_req", inst_req, 1'b0);
            prev_hold = inst_req && !inst_addr_ok;
            prev_addr = inst_addr;
        end else begin
            prev_hold = 1'b0;
            bus_busy  = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit          busy;
        bit          out_pending;
        int          gap;
        int          dly;
        int          fetched;
        logic [31:0] pc;
        logic [31:0] rd_addr;

        rst = 1'b0; pcF = '0; instr_enF = 1'b0; longest_stall = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        #12;
        chk("rst_req", inst_req, 1'b0);
        chk("rst_stall", instrStall, 1'b0);
        chk("rst_instr", instrF, 32'h0);
        next_cycle();
        rst = 1'b1;

        // Best case: addr_ok in the request cycle, data_ok in the next cycle
        next_cycle();
        pcF = 32'hBFC0_0000; instr_enF = 1'b1; inst_addr_ok = 1'b1;
        chk_out("t1_c0", 1'b1, 1'b1, 32'h0);
        chk("t1_addr", inst_addr, 32'hBFC0_0000);
        next_cycle();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        chk_out("t1_c1", 1'b0, 1'b0, 32'h2408_0001);
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;
        chk_out("t1_idle", 1'b0, 1'b0, 32'h0);

        // addr_ok arrives 3 cycles late. pcF is disturbed to prove the address is held.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            instr_enF = 1'b1;
            pcF = (i == 0) ? 32'hBFC0_0000 : 32'h1234_5678;
            inst_addr_ok = (i == 3);
            chk_out("t2_req", 1'b1, 1'b1, 32'h0);
            chk("t2_addr", inst_addr, 32'hBFC0_0000);
        end
        next_cycle();
        inst_addr_ok = 1'b0;
        chk_out("t2_wait", 1'b0, 1'b1, 32'h0);
        next_cycle();
        inst_data_ok = 1'b1; inst_rdata = 32'h3C1D_BFC0;
        chk_out("t2_data", 1'b0, 1'b0, 32'h3C1D_BFC0);
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;

        // Data returns while the pipeline is frozen for two more cycles
        next_cycle();
        pcF = 32'hBFC0_0004; instr_enF = 1'b1; inst_addr_ok = 1'b1;
        next_cycle();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C02_0004;
        longest_stall = 1'b1;
        chk_out("t3_data", 1'b0, 1'b0, 32'h8C02_0004);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            inst_data_ok = 1'b0; inst_rdata = 32'hDEAD_BEEF;
            chk_out("t3_done", 1'b0, 1'b0, 32'h8C02_0004);
        end
        next_cycle();
        longest_stall = 1'b0;
        chk_out("t3_release", 1'b0, 1'b0, 32'h8C02_0004);
        next_cycle();
        pcF = 32'hBFC0_0008; inst_addr_ok = 1'b1;
        chk_out("t3_newreq", 1'b1, 1'b1, 32'h0);
        chk("t3_newaddr", inst_addr, 32'hBFC0_0008);
        next_cycle();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0000;
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;

        // Idle with a stray data_ok pulse
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            inst_data_ok = (i == 2); inst_rdata = 32'hFFFF_FFFF;
            chk_out("t4_idle", 1'b0, 1'b0, 32'h0);
        end
        next_cycle();
        inst_data_ok = 1'b0; pcF = 32'hBFC0_000C; instr_enF = 1'b1; inst_addr_ok = 1'b1;
        chk_out("t4_req", 1'b1, 1'b1, 32'h0);
        next_cycle();
        inst_addr_ok = 1'b0;
        chk_out("t4_wait", 1'b0, 1'b1, 32'h0);
        next_cycle();
        inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
        chk_out("t4_data", 1'b0, 1'b0, 32'h1111_1111);
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;

        // Reset in WAIT aborts at once. data_ok after release is ignored.
        next_cycle();
        pcF = 32'hBFC0_0010; instr_enF = 1'b1; inst_addr_ok = 1'b1;
        next_cycle();
        inst_addr_ok = 1'b0;
        #2;
        rst = 1'b0; instr_enF = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
        #1;
        chk("t5_rst_req", inst_req, 1'b0);
        chk("t5_rst_stall", instrStall, 1'b0);
        chk("t5_rst_instr", instrF, 32'h0);
        next_cycle();
        rst = 1'b1;
        chk_out("t5_stray", 1'b0, 1'b0, 32'h0);
        next_cycle();
        inst_data_ok = 1'b0; pcF = 32'hBFC0_0020; instr_enF = 1'b1;
        chk_out("t5_req", 1'b1, 1'b1, 32'h0);
        chk("t5_addr", inst_addr, 32'hBFC0_0020);
        next_cycle();
        inst_addr_ok = 1'b1;
        chk_out("t5_reqhold", 1'b1, 1'b1, 32'h0);
        chk("t5_addrhold", inst_addr, 32'hBFC0_0020);
        next_cycle();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h7777_0077;
        chk_out("t5_data", 1'b0, 1'b0, 32'h7777_0077);
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;

        // Randomized phase: core model and bus model in one loop, monitor checks
        busy = 1'b0; out_pending = 1'b0; gap = 0; dly = 0; fetched = 0;
        pc = '0; rd_addr = '0;
        next_cycle();
        rnd = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc != 0) next_cycle();
            // bus side
            inst_addr_ok = ($urandom_range(0, 2) == 0);
            if (out_pending) begin
                if (dly == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem(rd_addr);
                    out_pending  = 1'b0;
                end else begin
                    dly--;
                    inst_data_ok = 1'b0;
                end
            end else begin
                inst_data_ok = ($urandom_range(0, 7) == 0);
                inst_rdata   = $urandom;
            end
            // core side
            if (!busy) begin
                if (gap > 0) begin
                    gap--;
                    instr_enF = 1'b0;
                    pcF = $urandom;
                end else begin
                    pc = $urandom & 32'hFFFF_FFFC;
                    pcF = pc;
                    instr_enF = 1'b1;
                    busy = 1'b1;
                    pc_q.push_back(pc);
                    exp_q.push_back(mem(pc));
                end
            end
            longest_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (inst_req && inst_addr_ok) begin
                out_pending = 1'b1;
                rd_addr = inst_addr;
                dly = $urandom_range(0, 3);
            end
            if (busy && !instrStall && !longest_stall) begin
                busy = 1'b0;
                gap = $urandom_range(0, 2);
                fetched++;
                if (fetched >= 150) break;
            end
        end
        next_cycle();
        rnd = 1'b0;
        instr_enF = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; longest_stall = 1'b0;
        if (fetched < 150) fail("rand_timeout", $sformatf("got %0d fetches, required 150", fetched));
        chk("rand_exp_left", exp_q.size(), 0);
        chk("rand_pc_left", pc_q.size(), 0);

`ifdef IBRIDGE_PERF_CNT_EN
        // Three fetches, each with addr_ok one cycle late and data_ok right after
        next_cycle();
        rst = 1'b0;
        #1;
        chk("perf_rst_req", perf_req_cnt, 32'h0);
        chk("perf_rst_stall", perf_stall_cnt, 32'h0);
        next_cycle();
        rst = 1'b1;
        for (int f = 0; f < 3; f++) begin
            next_cycle();
            pcF = 32'hBFC0_0100 + 32'(f * 4); instr_enF = 1'b1; inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            next_cycle();
            inst_addr_ok = 1'b1;
            next_cycle();
            inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_1000 + 32'(f);
        end
        next_cycle();
        instr_enF = 1'b0; inst_data_ok = 1'b0;
        @(negedge clk);
        chk("perf_req_cnt", perf_req_cnt, 32'd3);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
